// File: rtl/base_emux_arb.sv
// ---------------------------------------------------------------------------
// base_emux_arb
//
// Round-robin arbiter and sequencer in front of a pipelined wide select mux
// (the multi-cycle emux). One mux instance is shared by `ways` requesters.
// The winner's index drives the mux select in the grant cycle. A matching
// {valid, tag} delay line of mux_lat stages runs beside the mux, so o_v/o_tag
// line up with the mux dout for that beat. The mux pipeline cannot stall.
// For that reason, issue is gated by a credit counter that tracks free slots
// in the downstream buffer.
//
// Ports
//   clk        in   clock
//   reset      in   asynchronous active-high reset
//   i_r_v      in   [0:ways-1]  request valid, bit i = requester i
//   i_mask     in   [0:ways-1]  1 = requester eligible
//   o_r_r      out  [0:ways-1]  grant/ready, one-hot or zero (combinational)
//   o_sel      out  [0:sel_width-1] mux select, winner index or 0 (comb.)
//   o_v        out  output valid, aligned with mux dout (registered)
//   o_tag      out  [0:sel_width-1] requester index of the o_v beat (reg.)
//   i_crd_ret  in   one credit returned by downstream this cycle
//   o_crd_cnt  out  [0:7] credits currently available (registered)
//   o_perror   out  sticky credit-overflow error (registered)
// ---------------------------------------------------------------------------
module base_emux_arb #(
  parameter int ways       = 8,
  parameter int sel_width  = $clog2(ways),
  parameter int lsel_width = 3,
  parameter int mux_lat    = (sel_width + lsel_width - 1) / lsel_width,
  parameter int credits    = 8
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [0:ways-1]      i_r_v,
  input  logic [0:ways-1]      i_mask,
  output logic [0:ways-1]      o_r_r,
  output logic [0:sel_width-1] o_sel,
  output logic                 o_v,
  output logic [0:sel_width-1] o_tag,
  input  logic                 i_crd_ret,
  output logic [0:7]           o_crd_cnt,
  output logic                 o_perror
);

  localparam logic [7:0]           CRD_INIT = 8'(credits);
  localparam logic [sel_width-1:0] LAST_IDX = sel_width'(ways - 1);

  // Arbitration
  logic [0:ways-1]      elig_s;
  logic                 found_s;
  logic [sel_width-1:0] win_s;
  logic                 crd_ok_s;
  logic                 gnt_s;
  logic [sel_width-1:0] sel_s;
  logic [sel_width-1:0] ptr_r;
  logic [sel_width-1:0] ptr_nxt_s;

  // Credits
  logic [7:0]           crd_r;
  logic [7:0]           crd_nxt_s;
  logic                 perr_r;
  logic                 perr_nxt_s;

  // {valid, tag} delay line matched to the mux latency
  logic                 v_r   [mux_lat];
  logic [sel_width-1:0] tag_r [mux_lat];

  // Eligibility: a requester competes only while it requests and is unmasked.
  always_comb begin
    elig_s = i_r_v & i_mask;
  end

  // Round-robin winner search. The first pass covers ptr..ways-1. The second
  // pass covers 0..ptr-1. This makes the wrap explicit without a modulo, so
  // ways need not be a power of two.
  always_comb begin
    logic hit_s;
    found_s = 1'b0;
    win_s   = '0;
    hit_s   = 1'b0;
    for (int i = 0; i < ways; i++) begin
      hit_s   = !found_s && elig_s[i] && (i >= int'(ptr_r));
      found_s = found_s | hit_s;
      win_s   = hit_s ? sel_width'(i) : win_s;
    end
    for (int i = 0; i < ways; i++) begin
      hit_s   = !found_s && elig_s[i] && (i < int'(ptr_r));
      found_s = found_s | hit_s;
      win_s   = hit_s ? sel_width'(i) : win_s;
    end
  end

  // Grant qualification: issue is possible only while a downstream slot is
  // free, since a beat that has entered the mux can never be held back.
  always_comb begin
    crd_ok_s = (crd_r != 8'd0);
    gnt_s    = found_s & crd_ok_s;
    sel_s    = gnt_s ? win_s : '0;
  end

  // Grant vector and mux select, same-cycle.
  always_comb begin
    for (int i = 0; i < ways; i++) begin
      o_r_r[i] = gnt_s && (win_s == sel_width'(i));
    end
    o_sel = sel_s;
  end

  // Next pointer: the slot just after the winner, wrapping at ways-1.
  always_comb begin
    if (!gnt_s) begin
      ptr_nxt_s = ptr_r;
    end else if (win_s == LAST_IDX) begin
      ptr_nxt_s = '0;
    end else begin
      ptr_nxt_s = win_s + sel_width'(1);
    end
  end

  // Credit next-state. A grant and a return in the same cycle cancel out.
  // A return while the counter is full is an overflow. In that case the count
  // saturates and the sticky error is raised.
  always_comb begin
    crd_nxt_s  = crd_r;
    perr_nxt_s = perr_r;
    case ({gnt_s, i_crd_ret})
      2'b10: begin
        crd_nxt_s = crd_r - 8'd1;
      end
      2'b01: begin
        if (crd_r == CRD_INIT) begin
          perr_nxt_s = 1'b1;
        end else begin
          crd_nxt_s = crd_r + 8'd1;
        end
      end
      default: begin
        crd_nxt_s = crd_r;
      end
    endcase
  end

  // Round-robin pointer register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ptr_r <= '0;
    end else begin
      ptr_r <= ptr_nxt_s;
    end
  end

  // Credit counter and sticky overflow flag.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      crd_r  <= CRD_INIT;
      perr_r <= 1'b0;
    end else begin
      crd_r  <= crd_nxt_s;
      perr_r <= perr_nxt_s;
    end
  end

  // Valid/tag shift register. Reset discards all beats in flight.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int k = 0; k < mux_lat; k++) begin
        v_r[k]   <= 1'b0;
        tag_r[k] <= '0;
      end
    end else begin
      v_r[0]   <= gnt_s;
      tag_r[0] <= sel_s;
      for (int k = 1; k < mux_lat; k++) begin
        v_r[k]   <= v_r[k-1];
        tag_r[k] <= tag_r[k-1];
      end
    end
  end

  // Registered outputs.
  always_comb begin
    o_v       = v_r[mux_lat-1];
    o_tag     = tag_r[mux_lat-1];
    o_crd_cnt = crd_r;
    o_perror  = perr_r;
  end

endmodule

// File: tb/tb_base_emux_arb.sv
// ---------------------------------------------------------------------------
// tb_base_emux_arb
//
// Self-checking bench for base_emux_arb. It uses three instances:
//   d0: ways=8,  credits=8 (mux_lat=1)
//   d1: ways=8,  credits=2 (mux_lat=1)
//   d2: ways=64, credits=8 (sel_width=6, mux_lat=2)
// The instances share clock and reset. A behavioural model tracks them:
//   - The winner is found by a modular scan from the pointer.
//   - The output beat is looked up from a per-cycle grant history
//     (a grant in cycle N appears in cycle N+lat).
//   - The credit count is plain arithmetic.
// Directed scenario tasks compare against hand-derived constants. The random
// task compares against the model.
// ---------------------------------------------------------------------------
module tb_base_emux_arb;

  localparam int ND = 3;
  localparam int W [ND] = '{8, 8, 64};
  localparam int C [ND] = '{8, 2, 8};
  localparam int L [ND] = '{1, 1, 2};
  localparam int HMAX = 4096;

  logic clk = 1'b0;
  logic reset;
  logic [0:63] rv  [ND];
  logic [0:63] mk  [ND];
  logic        ret [ND];

  logic [0:7]  rr0, rr1;
  logic [0:63] rr2;
  logic [0:2]  sel0, sel1, tag0, tag1;
  logic [0:5]  sel2, tag2;
  logic        v0, v1, v2, pe0, pe1, pe2;
  logic [0:7]  cnt0, cnt1, cnt2;

  logic [0:63] a_rr  [ND];
  logic [31:0] a_sel [ND];
  logic [31:0] a_tag [ND];
  logic        a_v   [ND];
  logic        a_pe  [ND];
  logic [7:0]  a_cnt [ND];

  int n_checks = 0;
  int n_errs   = 0;

  // model state
  int          cyc = 0;
  int          m_ptr  [ND];
  int          m_cnt  [ND];
  bit          m_perr [ND];
  bit          e_g    [ND];
  int          e_w    [ND];
  logic [0:63] e_rr   [ND];
  bit          e_v    [ND];
  int          e_tag  [ND];
  bit          hv [ND][HMAX];
  int          ht [ND][HMAX];

  always #5 clk = ~clk;

  base_emux_arb #(.ways(8), .credits(8)) u_d0 (
    .clk(clk), .reset(reset), .i_r_v(rv[0][0:7]), .i_mask(mk[0][0:7]),
    .o_r_r(rr0), .o_sel(sel0), .o_v(v0), .o_tag(tag0),
    .i_crd_ret(ret[0]), .o_crd_cnt(cnt0), .o_perror(pe0));

  base_emux_arb #(.ways(8), .credits(2)) u_d1 (
    .clk(clk), .reset(reset), .i_r_v(rv[1][0:7]), .i_mask(mk[1][0:7]),
    .o_r_r(rr1), .o_sel(sel1), .o_v(v1), .o_tag(tag1),
    .i_crd_ret(ret[1]), .o_crd_cnt(cnt1), .o_perror(pe1));

  base_emux_arb #(.ways(64), .credits(8)) u_d2 (
    .clk(clk), .reset(reset), .i_r_v(rv[2]), .i_mask(mk[2]),
    .o_r_r(rr2), .o_sel(sel2), .o_v(v2), .o_tag(tag2),
    .i_crd_ret(ret[2]), .o_crd_cnt(cnt2), .o_perror(pe2));

  assign a_rr[0]  = {rr0, 56'd0};
  assign a_rr[1]  = {rr1, 56'd0};
  assign a_rr[2]  = rr2;
  assign a_sel[0] = 32'(sel0);
  assign a_sel[1] = 32'(sel1);
  assign a_sel[2] = 32'(sel2);
  assign a_tag[0] = 32'(tag0);
  assign a_tag[1] = 32'(tag1);
  assign a_tag[2] = 32'(tag2);
  assign a_v[0]   = v0;
  assign a_v[1]   = v1;
  assign a_v[2]   = v2;
  assign a_pe[0]  = pe0;
  assign a_pe[1]  = pe1;
  assign a_pe[2]  = pe2;
  assign a_cnt[0] = 8'(cnt0);
  assign a_cnt[1] = 8'(cnt1);
  assign a_cnt[2] = 8'(cnt2);

  // Model: this cycle's expected combinational and registered outputs.
  task automatic m_eval();
    for (int d = 0; d < ND; d++) begin
      if (reset) begin
        m_ptr[d]  = 0;
        m_cnt[d]  = C[d];
        m_perr[d] = 1'b0;
        // beats granted in the last L cycles never emerge
        for (int g = cyc - L[d]; g <= cyc; g++) begin
          if (g >= 0) begin
            hv[d][g] = 1'b0;
            ht[d][g] = 0;
          end
        end
      end
      e_g[d] = 1'b0;
      e_w[d] = 0;
      if (m_cnt[d] != 0) begin
        for (int k = 0; k < W[d]; k++) begin
          int i;
          i = (m_ptr[d] + k) % W[d];
          if (!e_g[d] && rv[d][i] && mk[d][i]) begin
            e_g[d] = 1'b1;
            e_w[d] = i;
          end
        end
      end
      e_rr[d] = '0;
      if (e_g[d]) e_rr[d][e_w[d]] = 1'b1;
      e_v[d]   = (cyc >= L[d]) ? hv[d][cyc - L[d]] : 1'b0;
      e_tag[d] = (cyc >= L[d]) ? ht[d][cyc - L[d]] : 0;
    end
  endtask

  // Model: state update at the clock edge.
  task automatic m_commit();
    for (int d = 0; d < ND; d++) begin
      if (reset) begin
        hv[d][cyc] = 1'b0;
        ht[d][cyc] = 0;
      end else begin
        hv[d][cyc] = e_g[d];
        ht[d][cyc] = e_g[d] ? e_w[d] : 0;
        if (e_g[d]) m_ptr[d] = (e_w[d] + 1) % W[d];
        if (e_g[d] && !ret[d]) begin
          m_cnt[d] = m_cnt[d] - 1;
        end else if (!e_g[d] && ret[d]) begin
          if (m_cnt[d] == C[d]) m_perr[d] = 1'b1;
          else m_cnt[d] = m_cnt[d] + 1;
        end
      end
    end
    cyc++;
  endtask

  task automatic clear_inputs();
    for (int d = 0; d < ND; d++) begin
      rv[d]  = '0;
      mk[d]  = '1;
      ret[d] = 1'b0;
    end
  endtask

  task automatic settle();
    m_eval();
    #1;
  endtask

  task automatic next_cycle();
    m_eval();
    m_commit();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    clear_inputs();
    reset = 1'b1;
    next_cycle();
    reset = 1'b0;
  endtask

  task automatic test_reset();
    clear_inputs();
    reset = 1'b1;
    next_cycle();
    for (int pass = 0; pass < 2; pass++) begin
      settle();
      for (int d = 0; d < ND; d++) begin
        n_checks++;
        if (a_v[d] !== 1'b0 || a_tag[d] !== 32'd0 || a_rr[d] !== 64'd0 || a_sel[d] !== 32'd0) begin
          n_errs++;
          $display("FAIL reset_outs d%0d pass%0d: got v=%b tag=%0d rr=%h sel=%0d want zeros",
                   d, pass, a_v[d], a_tag[d], a_rr[d], a_sel[d]);
        end
        n_checks++;
        if (a_cnt[d] !== 8'(C[d]) || a_pe[d] !== 1'b0) begin
          n_errs++;
          $display("FAIL reset_crd d%0d pass%0d: got cnt=%0d pe=%b want cnt=%0d pe=0",
                   d, pass, a_cnt[d], a_pe[d], C[d]);
        end
      end
      next_cycle();
      reset = 1'b0;
    end
  endtask

  task automatic test_round_robin();
    do_reset();
    rv[0] = '1;
    for (int k = 0; k < 11; k++) begin
      logic [0:7] want_rr;
      settle();
      want_rr = (k < 8) ? (8'h80 >> k) : 8'h00;
      n_checks++;
      if (rr0 !== want_rr || a_sel[0] !== ((k < 8) ? 32'(k) : 32'd0)) begin
        n_errs++;
        $display("FAIL rr_grant k%0d: got rr=%b sel=%0d want rr=%b sel=%0d",
                 k, rr0, a_sel[0], want_rr, (k < 8) ? k : 0);
      end
      n_checks++;
      if (v0 !== (k >= 1 && k <= 8) || (k >= 1 && k <= 8 && a_tag[0] !== 32'(k - 1))) begin
        n_errs++;
        $display("FAIL rr_beat k%0d: got v=%b tag=%0d want v=%b tag=%0d",
                 k, v0, a_tag[0], (k >= 1 && k <= 8), k - 1);
      end
      n_checks++;
      if (a_cnt[0] !== 8'((k < 8) ? 8 - k : 0)) begin
        n_errs++;
        $display("FAIL rr_crd k%0d: got %0d want %0d", k, a_cnt[0], (k < 8) ? 8 - k : 0);
      end
      next_cycle();
    end
  endtask

  task automatic test_credit_limit();
    bit req_g [7] = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
    int cnt_w [7] = '{2, 1, 0, 0, 0, 1, 0};
    do_reset();
    rv[1][3] = 1'b1;
    for (int k = 0; k < 7; k++) begin
      ret[1] = (k == 4);
      settle();
      n_checks++;
      if (rr1 !== (req_g[k] ? 8'b0001_0000 : 8'b0) || a_cnt[1] !== 8'(cnt_w[k])) begin
        n_errs++;
        $display("FAIL crd_limit k%0d: got rr=%b cnt=%0d want rr=%b cnt=%0d",
                 k, rr1, a_cnt[1], req_g[k] ? 8'b0001_0000 : 8'b0, cnt_w[k]);
      end
      next_cycle();
    end
  endtask

  // Starts from d1 with zero credits left by test_credit_limit.
  task automatic test_crd_simul();
    bit req [7] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
    bit rt  [7] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0};
    int cw  [7] = '{0, 1, 1, 2, 2, 2, 1};
    bit pw  [7] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1};
    for (int k = 0; k < 7; k++) begin
      rv[1][3] = req[k];
      ret[1]   = rt[k];
      settle();
      n_checks++;
      if (a_cnt[1] !== 8'(cw[k]) || a_pe[1] !== pw[k] || rr1[3] !== req[k]) begin
        n_errs++;
        $display("FAIL crd_simul k%0d: got cnt=%0d pe=%b g=%b want cnt=%0d pe=%b g=%b",
                 k, a_cnt[1], a_pe[1], rr1[3], cw[k], pw[k], req[k]);
      end
      next_cycle();
    end
  endtask

  task automatic test_wrap_mask();
    logic [0:7] rq [8] = '{8'h04, 8'h24, 8'h24, 8'h24, 8'h20, 8'h20, 8'h20, 8'h24};
    bit         m2 [8] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
    int         ws [8] = '{5, 2, 5, 2, -1, -1, -1, 5};
    do_reset();
    for (int k = 0; k < 8; k++) begin
      rv[0][0:7] = rq[k];
      mk[0][2]   = m2[k];
      settle();
      n_checks++;
      if ((ws[k] >= 0 && (rr0 !== (8'h80 >> ws[k]) || a_sel[0] !== 32'(ws[k]))) ||
          (ws[k] < 0 && (rr0 !== 8'h00 || a_sel[0] !== 32'd0))) begin
        n_errs++;
        $display("FAIL wrap_mask k%0d: got rr=%b sel=%0d want winner %0d",
                 k, rr0, a_sel[0], ws[k]);
      end
      next_cycle();
    end
  endtask

  task automatic test_wide_reset();
    do_reset();
    for (int k = 0; k < 8; k++) begin
      rv[2]     = '0;
      rv[2][41] = (k == 0 || k == 4);
      reset     = (k == 5);
      settle();
      if (k == 0 || k == 4) begin
        n_checks++;
        if (a_sel[2] !== 32'd41 || rr2 !== (64'h8000_0000_0000_0000 >> 41)) begin
          n_errs++;
          $display("FAIL wide_sel k%0d: got sel=%0d rr=%h want sel=41", k, a_sel[2], rr2);
        end
      end
      n_checks++;
      if (v2 !== (k == 2) || (k == 2 && a_tag[2] !== 32'd41)) begin
        n_errs++;
        $display("FAIL wide_beat k%0d: got v=%b tag=%0d want v=%b tag=41",
                 k, v2, a_tag[2], (k == 2));
      end
      if (k >= 5) begin
        n_checks++;
        if (a_cnt[2] !== 8'd8) begin
          n_errs++;
          $display("FAIL wide_crd k%0d: got %0d want 8", k, a_cnt[2]);
        end
      end
      next_cycle();
    end
    reset = 1'b0;
  endtask

  task automatic test_random();
    do_reset();
    for (int k = 0; k < 600; k++) begin
      reset = ($urandom_range(0, 99) == 0);
      for (int d = 0; d < ND; d++) begin
        rv[d]  = {$urandom, $urandom} & {$urandom, $urandom};
        mk[d]  = {$urandom, $urandom} | {$urandom, $urandom};
        ret[d] = ($urandom_range(0, 99) < 35);
      end
      settle();
      for (int d = 0; d < ND; d++) begin
        n_checks++;
        if (a_rr[d] !== e_rr[d] || a_sel[d] !== (e_g[d] ? 32'(e_w[d]) : 32'd0)) begin
          n_errs++;
          $display("FAIL rand_grant d%0d cyc%0d: got rr=%h sel=%0d want rr=%h sel=%0d",
                   d, cyc, a_rr[d], a_sel[d], e_rr[d], e_g[d] ? e_w[d] : 0);
        end
        n_checks++;
        if (a_v[d] !== e_v[d] || a_tag[d] !== 32'(e_tag[d])) begin
          n_errs++;
          $display("FAIL rand_beat d%0d cyc%0d: got v=%b tag=%0d want v=%b tag=%0d",
                   d, cyc, a_v[d], a_tag[d], e_v[d], e_tag[d]);
        end
        n_checks++;
        if (a_cnt[d] !== 8'(m_cnt[d]) || a_pe[d] !== m_perr[d]) begin
          n_errs++;
          $display("FAIL rand_crd d%0d cyc%0d: got cnt=%0d pe=%b want cnt=%0d pe=%b",
                   d, cyc, a_cnt[d], a_pe[d], m_cnt[d], m_perr[d]);
        end
      end
      next_cycle();
    end
    reset = 1'b0;
  endtask

  initial begin
    reset = 1'b1;
    clear_inputs();
    for (int d = 0; d < ND; d++) begin
      m_ptr[d]  = 0;
      m_cnt[d]  = C[d];
      m_perr[d] = 1'b0;
    end
    #1;
    test_reset();
    test_round_robin();
    test_credit_limit();
    test_crd_simul();
    test_wrap_mask();
    test_wide_reset();
    test_random();
    $display("Result: errors=%0d of %0d checks", n_errs, n_checks);
    $finish;
  end

endmodule
